// File: rtl/lvds_frame_aligner.sv
// LVDS frame aligner: bitslips the deserializer until the frame word matches.
// Optional stats (align_fail, realign_cnt) built when LVDS_ALIGN_STATS_EN is defined.
module lvds_frame_aligner #(
  parameter int          NUM_LANES      = 2,
  parameter logic [5:0]  FRAME_PATTERN  = 6'b111000,
  parameter int          LOCK_WAIT      = 64,
  parameter int          MATCH_COUNT    = 8,
  parameter int          SETTLE_CYCLES  = 4,
  parameter int          MISMATCH_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic [5:0]             frame_word,
  input  logic [6*NUM_LANES-1:0] data_in,
  output logic                   bitslip,
  output logic                   aligned,
  output logic [6*NUM_LANES-1:0] data_out,
  output logic                   data_valid,
  output logic [2:0]             slip_cnt,
  output logic                   align_fail,
  output logic [7:0]             realign_cnt
);

  localparam int M1   = (LOCK_WAIT > MATCH_COUNT) ? LOCK_WAIT : MATCH_COUNT;
  localparam int M2   = (SETTLE_CYCLES > MISMATCH_LIMIT) ? SETTLE_CYCLES : MISMATCH_LIMIT;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOCK,
    S_CHECK,
    S_SLIP,
    S_SETTLE,
    S_ALIGNED
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             slip_q, slip_d;
  logic                   lock_m_q, lock_s_q;
  logic                   bitslip_q, aligned_q;
  logic [6*NUM_LANES-1:0] dout_q;
  logic                   match;

  assign match = (frame_word == FRAME_PATTERN);

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      lock_m_q <= pll_locked;
      lock_s_q <= lock_m_q;
    end
  end

  // Next-state logic; one shared counter is cleared on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slip_d  = slip_q;
    if (!lock_s_q) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
        S_WAIT_LOCK: begin
          if (cnt_q == CW'(LOCK_WAIT - 1)) begin
            state_d = S_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CHECK: begin
          if (match) begin
            if (cnt_q == CW'(MATCH_COUNT - 1)) begin
              state_d = S_ALIGNED;
              cnt_d   = '0;
              slip_d  = 3'd0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = S_SLIP;
            cnt_d   = '0;
          end
        end
        S_SLIP: begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          slip_d  = (slip_q == 3'd5) ? 3'd0 : slip_q + 3'd1;
        end
        S_SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
            state_d = S_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_ALIGNED: begin
          if (match) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(MISMATCH_LIMIT - 1)) begin
            state_d = S_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      slip_q    <= 3'd0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slip_q    <= slip_d;
      bitslip_q <= (state_d == S_SLIP);
      aligned_q <= (state_d == S_ALIGNED);
      dout_q    <= data_in;
    end
  end

  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign data_valid = aligned_q;
  assign data_out   = dout_q;
  assign slip_cnt   = slip_q;

`ifdef LVDS_ALIGN_STATS_EN
  logic       slip_ev, lock_ev, realign_ev;
  logic [3:0] tot_q, tot_d;
  logic       fail_q, fail_d;
  logic [7:0] rea_q, rea_d;

  assign slip_ev    = (state_q == S_SLIP) && (state_d == S_SETTLE);
  assign lock_ev    = (state_q != S_ALIGNED) && (state_d == S_ALIGNED);
  assign realign_ev = (state_q == S_ALIGNED) && (state_d == S_CHECK);

  // Total-slip tracking, sticky failure flag and realign counter.
  always_comb begin
    tot_d  = tot_q;
    fail_d = fail_q;
    rea_d  = rea_q;
    if (slip_ev) begin
      if (tot_q < 4'd12) tot_d = tot_q + 4'd1;
      if (tot_q == 4'd11) fail_d = 1'b1;
    end
    if (lock_ev) tot_d = 4'd0;
    if (realign_ev && (rea_q != 8'hFF)) rea_d = rea_q + 8'd1;
  end

  // Stats registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tot_q  <= 4'd0;
      fail_q <= 1'b0;
      rea_q  <= 8'd0;
    end else begin
      tot_q  <= tot_d;
      fail_q <= fail_d;
      rea_q  <= rea_d;
    end
  end

  assign align_fail  = fail_q;
  assign realign_cnt = rea_q;
`else
  assign align_fail  = 1'b0;
  assign realign_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lvds_frame_aligner.sv
// Self-checking bench for lvds_frame_aligner.
// Data path scoreboarded; alignment scenarios checked against derived timing.
module tb_lvds_frame_aligner;

  localparam int NL = 2;
  localparam int DW = 6 * NL;
  localparam int LAT = 2 + 64 + 8 + 1;
`ifdef LVDS_ALIGN_STATS_EN
  localparam logic [31:0] STATS = 32'd1;
`else
  localparam logic [31:0] STATS = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pll_locked = 1'b0;
  logic [5:0]    frame_word = 6'b111000;
  logic [DW-1:0] data_in = '0;
  logic          bitslip, aligned, data_valid, align_fail;
  logic [DW-1:0] data_out;
  logic [2:0]    slip_cnt;
  logic [7:0]    realign_cnt;

  lvds_frame_aligner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .frame_word (frame_word),
    .data_in    (data_in),
    .bitslip    (bitslip),
    .aligned    (aligned),
    .data_out   (data_out),
    .data_valid (data_valid),
    .slip_cnt   (slip_cnt),
    .align_fail (align_fail),
    .realign_cnt(realign_cnt)
  );

  always #10 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] sb_q[$];
  int            cyc_n = 0;
  int            last_bs = -1;
  int            bs_cnt = 0;
  bit            bs_prev = 1'b0;
  bit            use_rot = 1'b0;
  int            n;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock: deserializer model, bitslip monitor, data scoreboard.
  task automatic tick();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (use_rot && bs_prev)
      frame_word = {frame_word[4:0], frame_word[5]};
    bs_prev = bitslip;
    if (bitslip) begin
      if (last_bs >= 0) check("bs_gap", cyc_n - last_bs, 6);
      last_bs = cyc_n;
      bs_cnt++;
    end
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("data_out", {20'd0, data_out}, {20'd0, e});
    end
    if (rst_n) begin
      data_in = DW'($urandom);
      sb_q.push_back(data_in);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_bs"}, {31'd0, bitslip}, 0);
    check({p, "_aln"}, {31'd0, aligned}, 0);
    check({p, "_dout"}, {20'd0, data_out}, 0);
    check({p, "_dv"}, {31'd0, data_valid}, 0);
    check({p, "_slip"}, {29'd0, slip_cnt}, 0);
    check({p, "_fail"}, {31'd0, align_fail}, 0);
    check({p, "_rea"}, {24'd0, realign_cnt}, 0);
  endtask

  task automatic do_reset(input string p);
    rst_n = 1'b0;
    #1;
    check_zero(p);
    sb_q.delete();
    last_bs = -1;
    bs_prev = 1'b0;
    bs_cnt  = 0;
    repeat (3) tick();
    check_zero({p, "_hold"});
  endtask

  task automatic wait_aligned(output int cnt);
    cnt = 0;
    while (aligned !== 1'b1 && cnt < 600) begin
      tick();
      cnt++;
    end
    if (cnt >= 600) check("align_timeout", 0, 1);
  endtask

  task automatic wait_pulse(input string tag);
    int start;
    int k;
    start = bs_cnt;
    k = 0;
    while (bs_cnt == start && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check(tag, 0, 1);
  endtask

  initial begin
    #2;
    do_reset("rst0");

    // Lock with clean frame.
    frame_word = 6'b111000;
    pll_locked = 1'b1;
    rst_n = 1'b1;
    wait_aligned(n);
    check("lock_lat", n, LAT);
    check("clean_bs", bs_cnt, 0);
    check("clean_slip", {29'd0, slip_cnt}, 0);
    tick();
    check("clean_dv", {31'd0, data_valid}, 1);

    // Two corrupt words are tolerated.
    frame_word = 6'b000000;
    repeat (2) tick();
    frame_word = 6'b111000;
    repeat (4) tick();
    check("glitch2_aln", {31'd0, aligned}, 1);

    // Three corrupt words force realignment.
    frame_word = 6'b000000;
    repeat (3) tick();
    frame_word = 6'b111000;
    check("glitch3_aln", {31'd0, aligned}, 0);
    check("glitch3_rea", {24'd0, realign_cnt}, STATS);
    wait_aligned(n);
    check("realign_lat", n, 8);
    check("glitch_bs", bs_cnt, 0);

    // Loss of lock and relock.
    pll_locked = 1'b0;
    n = 0;
    while (aligned === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("unlock_within3", {31'd0, n <= 3}, 1);
    check("unlock_dv", {31'd0, data_valid}, 0);
    repeat (5) tick();
    pll_locked = 1'b1;
    wait_aligned(n);
    check("relock_lat", n, LAT);

    // Rotated frame: five slips to reach the pattern.
    do_reset("rst1");
    use_rot = 1'b1;
    frame_word = 6'b110001;
    rst_n = 1'b1;
    wait_aligned(n);
    check("rot_aln", {31'd0, aligned}, 1);
    check("rot_bs", bs_cnt, 5);
    check("rot_slip", {29'd0, slip_cnt}, 0);
    check("rot_frame", {26'd0, frame_word}, 32'h38);
    check("rot_fail", {31'd0, align_fail}, 0);
    use_rot = 1'b0;

    // Pattern never matches.
    do_reset("rst2");
    frame_word = 6'b000000;
    rst_n = 1'b1;
    for (int p = 1; p <= 13; p++) begin
      wait_pulse("pulse_timeout");
      tick();
      check($sformatf("nm_slip%0d", p), {29'd0, slip_cnt}, p % 6);
      if (p == 11) check("nm_fail11", {31'd0, align_fail}, 0);
      if (p >= 12) check($sformatf("nm_fail%0d", p), {31'd0, align_fail}, STATS);
    end
    check("nm_bs13", bs_cnt, 13);

    // Reset while settling, then full restart.
    do_reset("rst3");
    frame_word = 6'b111000;
    rst_n = 1'b1;
    wait_aligned(n);
    check("restart_lat", n, LAT);
    check("restart_slip", {29'd0, slip_cnt}, 0);
    check("restart_bs", bs_cnt, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
